// File: rtl/midi_byte_parser_if.sv
// midi_byte_parser_if
//  Groups the receiver-side byte stream and the midi_decoder-side outputs
//  of midi_byte_parser into one bundle.
//  master: byte producer / observer (drives rx_*, reads parser outputs)
//  slave : the parser itself (reads rx_*, drives parser outputs)
//  Signals:
//   rx_valid, rx_byte[7:0], rx_err              - received byte strobe
//   byteready, cur_status, midibyte_nr, midibyte - decoder data interface
//   sys_real, sys_real_dat                      - realtime byte split-out
//   sysex_end                                   - sysex closed by 0xF7
//   err_cnt[ERR_W-1:0]                          - saturating error count
interface midi_byte_parser_if #(
    parameter int ERR_W = 8
);
    logic             rx_valid;
    logic [7:0]       rx_byte;
    logic             rx_err;
    logic             byteready;
    logic [7:0]       cur_status;
    logic [7:0]       midibyte_nr;
    logic [7:0]       midibyte;
    logic             sys_real;
    logic [7:0]       sys_real_dat;
    logic             sysex_end;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output rx_valid, rx_byte, rx_err,
        input  byteready, cur_status, midibyte_nr, midibyte,
               sys_real, sys_real_dat, sysex_end, err_cnt
    );

    modport slave (
        input  rx_valid, rx_byte, rx_err,
        output byteready, cur_status, midibyte_nr, midibyte,
               sys_real, sys_real_dat, sysex_end, err_cnt
    );
endinterface

// File: rtl/midi_byte_parser.sv
// midi_byte_parser
//  Raw MIDI byte stream parser sitting between the serial receiver and
//  midi_decoder. Tracks running status, numbers data bytes within each
//  message, passes sysex data through (optionally) and splits out
//  realtime bytes. Every output is registered: it reflects the byte
//  presented one clock earlier.
//  Ports:
//   CLOCK_25 - system clock, rising edge
//   iRST     - asynchronous active-high reset
//   mif      - slave side of midi_byte_parser_if (rx stream in, decoder
//              interface / realtime / sysex_end / err_cnt out)
//  Parameters:
//   SYSEX_EN - 1: sysex data bytes are emitted on byteready; 0: discarded
//   ERR_W    - width of the saturating error counter
module midi_byte_parser #(
    parameter bit SYSEX_EN = 1'b1,
    parameter int ERR_W    = 8
) (
    input logic              CLOCK_25,
    input logic              iRST,
    midi_byte_parser_if.slave mif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no status known; data bytes are orphans
        CHAN  = 2'd1,   // channel message (running status)
        SYSEX = 2'd2,   // inside F0 ... F7
        SKIP  = 2'd3    // system-common data, discarded
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       cur_status_q, cur_status_d;
    logic [7:0]       nr_q, nr_d;
    logic [7:0]       mbyte_q, mbyte_d;
    logic [7:0]       rdat_q, rdat_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             byteready_q, byteready_d;
    logic             sys_real_q, sys_real_d;
    logic             sysex_end_q, sysex_end_d;

    logic [7:0]       b;
    logic [7:0]       cnt_inc;
    logic [7:0]       cnt_sat;
    logic [7:0]       msg_len;
    logic [ERR_W-1:0] err_inc;

    assign b       = mif.rx_byte;
    assign cnt_inc = cnt_q + 8'd1;
    assign cnt_sat = (cnt_q == 8'hFF) ? 8'hFF : cnt_inc;
    // Program change (Cx) and channel pressure (Dx) carry one data byte.
    assign msg_len = (cur_status_q[7:5] == 3'b110) ? 8'd1 : 8'd2;
    assign err_inc = (&err_q) ? err_q : err_q + ERR_W'(1);

    always_ff @(posedge CLOCK_25 or posedge iRST) begin
        if (iRST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cur_status_q <= '0;
            nr_q         <= '0;
            mbyte_q      <= '0;
            rdat_q       <= '0;
            err_q        <= '0;
            byteready_q  <= 1'b0;
            sys_real_q   <= 1'b0;
            sysex_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_status_q <= cur_status_d;
            nr_q         <= nr_d;
            mbyte_q      <= mbyte_d;
            rdat_q       <= rdat_d;
            err_q        <= err_d;
            byteready_q  <= byteready_d;
            sys_real_q   <= sys_real_d;
            sysex_end_q  <= sysex_end_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_status_d = cur_status_q;
        nr_d         = nr_q;
        mbyte_d      = mbyte_q;
        rdat_d       = rdat_q;
        err_d        = err_q;
        byteready_d  = 1'b0;
        sys_real_d   = 1'b0;
        sysex_end_d  = 1'b0;

        if (mif.rx_valid) begin
            if (mif.rx_err) begin
                // Corrupted byte: lose sync entirely until a new status byte.
                cur_status_d = '0;
                state_d      = IDLE;
                err_d        = err_inc;
            end else if (b >= 8'hF8) begin
                // Realtime bytes may interleave anything; touch no message state.
                sys_real_d = 1'b1;
                rdat_d     = b;
            end else if (!b[7]) begin
                unique case (state_q)
                    CHAN: begin
                        byteready_d = 1'b1;
                        mbyte_d     = b;
                        nr_d        = cnt_inc;
                        // Wrap on a complete message so running status restarts at nr 1.
                        cnt_d       = (cnt_inc == msg_len) ? 8'd0 : cnt_inc;
                    end
                    SYSEX: begin
                        cnt_d = cnt_sat;
                        if (SYSEX_EN) begin
                            byteready_d = 1'b1;
                            mbyte_d     = b;
                            nr_d        = cnt_sat;
                        end
                    end
                    SKIP: ;
                    IDLE: err_d = err_inc;
                    default: ;
                endcase
            end else if (b <= 8'hEF) begin
                cur_status_d = b;
                cnt_d        = '0;
                state_d      = CHAN;
            end else if (b == 8'hF0) begin
                cur_status_d = b;
                cnt_d        = '0;
                state_d      = SYSEX;
            end else if (b == 8'hF7) begin
                sysex_end_d  = (state_q == SYSEX);
                cur_status_d = '0;
                cnt_d        = '0;
                state_d      = IDLE;
            end else begin
                // F1..F6: system common, its data bytes are not ours to count.
                cur_status_d = '0;
                cnt_d        = '0;
                state_d      = SKIP;
            end
        end
    end

    assign mif.byteready    = byteready_q;
    assign mif.cur_status   = cur_status_q;
    assign mif.midibyte_nr  = nr_q;
    assign mif.midibyte     = mbyte_q;
    assign mif.sys_real     = sys_real_q;
    assign mif.sys_real_dat = rdat_q;
    assign mif.sysex_end    = sysex_end_q;
    assign mif.err_cnt      = err_q;

endmodule

// File: tb/tb_midi_byte_parser.sv
// tb_midi_byte_parser
//  Directed bench for midi_byte_parser. Two instances share one byte
//  stream: u_en (SYSEX_EN=1) and u_dis (SYSEX_EN=0). Bytes are driven on
//  the falling edge; outputs are sampled 1 time unit after the rising edge
//  that captured the byte.
module tb_midi_byte_parser;

    logic CLOCK_25 = 1'b0;
    logic iRST     = 1'b1;
    int   total    = 0;
    int   bad      = 0;

    always #5 CLOCK_25 = ~CLOCK_25;

    midi_byte_parser_if #(.ERR_W(8)) mif0 ();
    midi_byte_parser_if #(.ERR_W(8)) mif1 ();

    assign mif1.rx_valid = mif0.rx_valid;
    assign mif1.rx_byte  = mif0.rx_byte;
    assign mif1.rx_err   = mif0.rx_err;

    midi_byte_parser #(.SYSEX_EN(1'b1), .ERR_W(8)) u_en (
        .CLOCK_25 (CLOCK_25),
        .iRST     (iRST),
        .mif      (mif0.slave)
    );

    midi_byte_parser #(.SYSEX_EN(1'b0), .ERR_W(8)) u_dis (
        .CLOCK_25 (CLOCK_25),
        .iRST     (iRST),
        .mif      (mif1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the decoder-side outputs of the SYSEX_EN=1 instance.
    task automatic chk_dec(input string tag, input logic br, input logic [7:0] st,
                           input logic [7:0] nr, input logic [7:0] mb);
        chk({tag, ".br"}, 32'(mif0.byteready), 32'(br));
        chk({tag, ".st"}, 32'(mif0.cur_status), 32'(st));
        chk({tag, ".nr"}, 32'(mif0.midibyte_nr), 32'(nr));
        chk({tag, ".mb"}, 32'(mif0.midibyte), 32'(mb));
    endtask

    task automatic send(input logic [7:0] b, input logic e = 1'b0);
        @(negedge CLOCK_25);
        mif0.rx_valid = 1'b1;
        mif0.rx_byte  = b;
        mif0.rx_err   = e;
        @(posedge CLOCK_25);
        #1;
        mif0.rx_valid = 1'b0;
        mif0.rx_err   = 1'b0;
    endtask

    task automatic idle();
        @(negedge CLOCK_25);
        @(posedge CLOCK_25);
        #1;
    endtask

    initial begin
        mif0.rx_valid = 1'b0;
        mif0.rx_byte  = 8'h00;
        mif0.rx_err   = 1'b0;

        // Reset state
        repeat (3) @(posedge CLOCK_25);
        @(negedge CLOCK_25);
        chk_dec("rst", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("rst.sr",  32'(mif0.sys_real), 0);
        chk("rst.srd", 32'(mif0.sys_real_dat), 0);
        chk("rst.se",  32'(mif0.sysex_end), 0);
        chk("rst.err", 32'(mif0.err_cnt), 0);
        iRST = 1'b0;

        // Note on, then running status
        send(8'h90); chk_dec("n0", 1'b0, 8'h90, 8'h00, 8'h00);
        send(8'h3C); chk_dec("n1", 1'b1, 8'h90, 8'h01, 8'h3C);
        send(8'h64); chk_dec("n2", 1'b1, 8'h90, 8'h02, 8'h64);
        idle();      chk_dec("hold", 1'b0, 8'h90, 8'h02, 8'h64);
        send(8'h3E); chk_dec("rs1", 1'b1, 8'h90, 8'h01, 8'h3E);
        send(8'h00); chk_dec("rs2", 1'b1, 8'h90, 8'h02, 8'h00);

        // One-data-byte message, running status
        send(8'hC5);
        send(8'h07); chk_dec("pc1", 1'b1, 8'hC5, 8'h01, 8'h07);
        send(8'h09); chk_dec("pc2", 1'b1, 8'hC5, 8'h01, 8'h09);

        // Realtime interleaved in a message
        send(8'h90);
        send(8'h3C); chk_dec("rt0", 1'b1, 8'h90, 8'h01, 8'h3C);
        send(8'hF8); chk_dec("rt1", 1'b0, 8'h90, 8'h01, 8'h3C);
        chk("rt1.sr",  32'(mif0.sys_real), 1);
        chk("rt1.srd", 32'(mif0.sys_real_dat), 32'h F8);
        send(8'h64); chk_dec("rt2", 1'b1, 8'h90, 8'h02, 8'h64);
        chk("rt2.sr", 32'(mif0.sys_real), 0);

        // Sysex, both SYSEX_EN settings
        send(8'hF0); chk_dec("sx0", 1'b0, 8'hF0, 8'h02, 8'h64);
        send(8'h7D); chk_dec("sx1", 1'b1, 8'hF0, 8'h01, 8'h7D);
        chk("sx1.dis.br", 32'(mif1.byteready), 0);
        send(8'h01); chk_dec("sx2", 1'b1, 8'hF0, 8'h02, 8'h01);
        send(8'h02); chk_dec("sx3", 1'b1, 8'hF0, 8'h03, 8'h02);
        chk("sx3.dis.br", 32'(mif1.byteready), 0);
        send(8'hF7);
        chk("sxe.se",     32'(mif0.sysex_end), 1);
        chk("sxe.st",     32'(mif0.cur_status), 0);
        chk("sxe.dis.se", 32'(mif1.sysex_end), 1);
        chk("sxe.dis.st", 32'(mif1.cur_status), 0);
        chk("sxe.dis.mb", 32'(mif1.midibyte), 32'h64);
        idle();
        chk("sxe.pulse", 32'(mif0.sysex_end), 0);

        // Stray F7 outside sysex: no strobe
        send(8'hB0);
        send(8'hF7);
        chk("f7.se", 32'(mif0.sysex_end), 0);
        chk("f7.st", 32'(mif0.cur_status), 0);

        // Framing error mid-message, then orphan
        send(8'h90);
        send(8'h3C, 1'b1);
        chk("er1.err", 32'(mif0.err_cnt), 1);
        chk("er1.st",  32'(mif0.cur_status), 0);
        chk("er1.br",  32'(mif0.byteready), 0);
        send(8'h40);
        chk("er2.err", 32'(mif0.err_cnt), 2);
        chk("er2.br",  32'(mif0.byteready), 0);

        // System common data discarded, not counted as errors
        send(8'hF2);
        send(8'h10);
        send(8'h20);
        send(8'h45);
        chk("sc.err", 32'(mif0.err_cnt), 2);
        chk("sc.br",  32'(mif0.byteready), 0);
        chk("sc.st",  32'(mif0.cur_status), 0);

        // Status byte aborts a partial message
        send(8'h90);
        send(8'h3C);
        send(8'hB0); chk_dec("ab0", 1'b0, 8'hB0, 8'h01, 8'h3C);
        send(8'h07); chk_dec("ab1", 1'b1, 8'hB0, 8'h01, 8'h07);

        // Sysex count saturation at 255
        send(8'hF0);
        for (int i = 1; i <= 255; i++) send(8'(i & 8'h7F));
        chk_dec("sat255", 1'b1, 8'hF0, 8'hFF, 8'h7F);
        send(8'h11); chk_dec("sat256", 1'b1, 8'hF0, 8'hFF, 8'h11);

        // Async reset in the middle of "B0 07"
        send(8'hB0);
        @(negedge CLOCK_25);
        iRST = 1'b1;
        #1;
        chk_dec("arst", 1'b0, 8'h00, 8'h00, 8'h00);
        chk("arst.err", 32'(mif0.err_cnt), 0);
        @(negedge CLOCK_25);
        iRST = 1'b0;
        send(8'h07);
        chk("post.br",  32'(mif0.byteready), 0);
        chk("post.err", 32'(mif0.err_cnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
